// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Stage 1 registers per-bit and per-group generate/propagate; stage 2 resolves carries into the output.
module cla_pipe_adder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned GROUPSIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NG = WIDTH / GROUPSIZE;

  if ((WIDTH % GROUPSIZE) != 0) begin : g_bad_width
    $fatal(1, "cla_pipe_adder: WIDTH must be a multiple of GROUPSIZE");
  end

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [WIDTH-1:0] g_bit, p_bit;
  logic [NG-1:0]    g_grp, p_grp;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;
  assign g_bit = a & b_eff;
  assign p_bit = a ^ b_eff;

  // Group generate built LSB-first: G = g[msb] | p[msb]&(G of lower bits).
  always_comb begin
    g_grp = '0;
    p_grp = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      logic gk, pk;
      gk = 1'b0;
      pk = 1'b1;
      for (int unsigned j = 0; j < GROUPSIZE; j++) begin
        gk = g_bit[k*GROUPSIZE+j] | (p_bit[k*GROUPSIZE+j] & gk);
        pk = pk & p_bit[k*GROUPSIZE+j];
      end
      g_grp[k] = gk;
      p_grp[k] = pk;
    end
  end

  logic             s1_valid;
  logic [WIDTH-1:0] s1_g, s1_p;
  logic [NG-1:0]    s1_gg, s1_pp;
  logic             s1_c0, s1_amsb, s1_bmsb;
  logic             adv2, in_xfer;

  assign adv2     = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || adv2;
  assign in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_gg    <= '0;
      s1_pp    <= '0;
      s1_c0    <= 1'b0;
      s1_amsb  <= 1'b0;
      s1_bmsb  <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_g     <= g_bit;
      s1_p     <= p_bit;
      s1_gg    <= g_grp;
      s1_pp    <= p_grp;
      s1_c0    <= c0;
      s1_amsb  <= a[WIDTH-1];
      s1_bmsb  <= b_eff[WIDTH-1];
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] bit_c;
  logic [WIDTH-1:0] sum_next;
  logic             ovf_next;

  always_comb begin
    grp_c    = '0;
    grp_c[0] = s1_c0;
    for (int unsigned k = 0; k < NG; k++) begin
      grp_c[k+1] = s1_gg[k] | (s1_pp[k] & grp_c[k]);
    end
    bit_c = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      logic c;
      c = grp_c[k];
      for (int unsigned j = 0; j < GROUPSIZE; j++) begin
        bit_c[k*GROUPSIZE+j] = c;
        c = s1_g[k*GROUPSIZE+j] | (s1_p[k*GROUPSIZE+j] & c);
      end
    end
    sum_next = s1_p ^ bit_c;
    ovf_next = (s1_amsb == s1_bmsb) && (sum_next[WIDTH-1] != s1_amsb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (adv2) begin
      out_valid <= 1'b1;
      sum       <= sum_next;
      cout      <= grp_c[NG];
      overflow  <= ovf_next;
      zero      <= ~|sum_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (32/4 main instance plus a 16/8 instance).
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;

  logic        in_ready, out_valid, cout, overflow, zero;
  logic [31:0] sum;
  logic        in_ready16, out_valid16, cout16, overflow16, zero16;
  logic [15:0] sum16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(32), .GROUPSIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
  );

  cla_pipe_adder #(.WIDTH(16), .GROUPSIZE(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(out_valid16),
    .out_ready(out_ready), .sum(sum16), .cout(cout16), .overflow(overflow16), .zero(zero16)
  );

  // One transfer, then return at the negedge where the result is visible.
  task automatic send_op(input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input logic cv);
    @(negedge clk);
    a = av; b = bv; sub = sv; cin = cv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({out_valid, sum, cout, overflow, zero, in_ready} !== {1'b0, 32'h0, 3'b000, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got v=%b s=%h c=%b o=%b z=%b r=%b want v=0 s=0 c=0 o=0 z=0 r=1",
               out_valid, sum, cout, overflow, zero, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_ripple;
    send_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    total++;
    if ({out_valid, sum, cout, overflow, zero} !== {1'b1, 32'h0, 1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL add_ripple: got v=%b s=%h c=%b o=%b z=%b want v=1 s=00000000 c=1 o=0 z=1",
               out_valid, sum, cout, overflow, zero);
    end
    send_op(32'd100, 32'd23, 1'b0, 1'b1);
    total++;
    if ({out_valid, sum, cout, overflow, zero} !== {1'b1, 32'd124, 3'b000}) begin
      bad++;
      $display("FAIL add_cin: got v=%b s=%h c=%b o=%b z=%b want v=1 s=0000007c c=0 o=0 z=0",
               out_valid, sum, cout, overflow, zero);
    end
  endtask

  task automatic test_sub;
    send_op(32'd5, 32'd7, 1'b1, 1'b0);
    total++;
    if ({out_valid, sum, cout, overflow, zero} !== {1'b1, 32'hFFFF_FFFE, 3'b000}) begin
      bad++;
      $display("FAIL sub_borrow: got v=%b s=%h c=%b o=%b z=%b want v=1 s=fffffffe c=0 o=0 z=0",
               out_valid, sum, cout, overflow, zero);
    end
    send_op(32'd7, 32'd5, 1'b1, 1'b0);
    total++;
    if ({out_valid, sum, cout, overflow, zero} !== {1'b1, 32'd2, 3'b100}) begin
      bad++;
      $display("FAIL sub_noborrow: got v=%b s=%h c=%b o=%b z=%b want v=1 s=00000002 c=1 o=0 z=0",
               out_valid, sum, cout, overflow, zero);
    end
    // cin must be ignored in subtract mode
    send_op(32'd9, 32'd9, 1'b1, 1'b1);
    total++;
    if ({sum, cout, overflow, zero} !== {32'h0, 3'b101}) begin
      bad++;
      $display("FAIL sub_equal: got s=%h c=%b o=%b z=%b want s=00000000 c=1 o=0 z=1",
               sum, cout, overflow, zero);
    end
  endtask

  task automatic test_overflow;
    send_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    total++;
    if ({sum, cout, overflow, zero} !== {32'h8000_0000, 3'b010}) begin
      bad++;
      $display("FAIL add_overflow: got s=%h c=%b o=%b z=%b want s=80000000 c=0 o=1 z=0",
               sum, cout, overflow, zero);
    end
    send_op(32'h8000_0000, 32'd1, 1'b1, 1'b0);
    total++;
    if ({sum, cout, overflow, zero} !== {32'h7FFF_FFFF, 3'b110}) begin
      bad++;
      $display("FAIL sub_overflow: got s=%h c=%b o=%b z=%b want s=7fffffff c=1 o=1 z=0",
               sum, cout, overflow, zero);
    end
  endtask

  task automatic test_back_to_back;
    drain();
    for (int n = 0; n < 10; n++) begin
      total++;
      if (n < 2) begin
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL b2b_early n=%0d: got v=%b want v=0", n, out_valid);
        end
      end else if ({out_valid, sum} !== {1'b1, 32'(2 * (n - 2))}) begin
        bad++;
        $display("FAIL b2b_result n=%0d: got v=%b s=%0d want v=1 s=%0d",
                 n, out_valid, sum, 2 * (n - 2));
      end
      if (n < 8) begin
        a = 32'(n); b = 32'(n); sub = 1'b0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_in_ready n=%0d: got %b want 1", n, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_tail: got v=%b want v=0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    drain();
    out_ready = 1'b0; sub = 1'b0; cin = 1'b0;
    a = 32'd10; b = 32'd1; in_valid = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_accept1: got in_ready=%b want 1", in_ready);
    end
    @(posedge clk); @(negedge clk);
    a = 32'd20; b = 32'd2;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_accept2: got in_ready=%b want 1", in_ready);
    end
    @(posedge clk); @(negedge clk);
    a = 32'd30; b = 32'd3;
    total++;
    if ({in_ready, out_valid, sum} !== {2'b01, 32'd11}) begin
      bad++;
      $display("FAIL bp_full: got r=%b v=%b s=%0d want r=0 v=1 s=11", in_ready, out_valid, sum);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if ({in_ready, out_valid, sum} !== {2'b01, 32'd11}) begin
      bad++;
      $display("FAIL bp_hold: got r=%b v=%b s=%0d want r=0 v=1 s=11", in_ready, out_valid, sum);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if ({out_valid, sum} !== {1'b1, 32'd22}) begin
      bad++;
      $display("FAIL bp_second: got v=%b s=%0d want v=1 s=22", out_valid, sum);
    end
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL bp_no_dup n=%0d: got v=%b s=%0d want v=0", n, out_valid, sum);
      end
    end
  endtask

  task automatic test_reset_mid;
    drain();
    out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
    a = 32'd1; b = 32'd1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    a = 32'd2; b = 32'd2; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if ({out_valid, sum} !== {1'b1, 32'd2}) begin
      bad++;
      $display("FAIL rm_inflight: got v=%b s=%0d want v=1 s=2", out_valid, sum);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, sum, in_ready, out_valid16, sum16} !== {1'b0, 32'h0, 1'b1, 1'b0, 16'h0}) begin
      bad++;
      $display("FAIL rm_async: got v=%b s=%h r=%b v16=%b s16=%h want v=0 s=0 r=1 v16=0 s16=0",
               out_valid, sum, in_ready, out_valid16, sum16);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_valid16} !== 2'b00) begin
        bad++;
        $display("FAIL rm_quiet n=%0d: got v=%b v16=%b want 0 0", n, out_valid, out_valid16);
      end
    end
  endtask

  task automatic test_w16;
    send_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    total++;
    if ({out_valid16, sum16, cout16, overflow16, zero16} !== {1'b1, 16'h0, 3'b101}) begin
      bad++;
      $display("FAIL w16_ripple: got v=%b s=%h c=%b o=%b z=%b want v=1 s=0000 c=1 o=0 z=1",
               out_valid16, sum16, cout16, overflow16, zero16);
    end
    send_op(32'h0000_1234, 32'h0000_0234, 1'b1, 1'b0);
    total++;
    if ({sum16, cout16, overflow16, zero16} !== {16'h1000, 3'b100}) begin
      bad++;
      $display("FAIL w16_sub: got s=%h c=%b o=%b z=%b want s=1000 c=1 o=0 z=0",
               sum16, cout16, overflow16, zero16);
    end
  endtask

  initial begin
    test_reset();
    test_add_ripple();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_w16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor. Built from GROUPSIZE-bit lookahead groups with group-level lookahead carry.
- Next generation of the single-group CLA generator. Adds arbitrary WIDTH, an add/sub mode, status flags and a valid/ready elastic pipeline.
- Sits between the ALU operand mux and the ALU result mux.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of GROUPSIZE.
- GROUPSIZE, 4, bits per lookahead group; NG = WIDTH/GROUPSIZE groups.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  stage 1 can accept
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in (add mode only)
- sub  input  1  1 = A - B, 0 = A + B + cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (in sub mode, 1 = no borrow)
- overflow  output  1  signed overflow
- zero  output  1  sum == 0

Behaviour:
- Reset (async assert, sync-released by the caller): s1_valid=0, out_valid=0, sum=0, cout=0, overflow=0, zero=0. All stage registers clear to 0.
- Operand prep: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage 1 registers:
  - per-bit g = a & b_eff and p = a ^ b_eff;
  - per-group G[k] = g[msb] | p[msb]&g[msb-1] | ... and P[k] = AND of p over the group;
  - c0, a[MSB], b_eff[MSB].
- Stage 2 (combinational from stage 1, registered into the output):
  - group carries C[0] = c0, C[k+1] = G[k] | P[k]&C[k];
  - in-group carries c[i+1] = g[i] | p[i]&c[i], seeded with C[k];
  - sum[i] = p[i] ^ c[i]; cout = C[NG];
  - overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
  - zero = ~|sum.
- Handshake:
  - Transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
  - adv2 = s1_valid && (!out_valid || out_ready). in_ready = !s1_valid || adv2.
  - On adv2: output registers load and out_valid=1. Else, if out_ready, out_valid clears.
  - Stage 1 loads on input transfer. Else, if adv2, s1_valid clears.
- Latency: 2 cycles from input transfer to out_valid. Throughput 1 result/cycle with out_ready held high.
- Backpressure:
  - With out_ready low, the output holds stable and s1 holds.
  - Max 2 results in flight. in_ready deasserts only when both stages are full and out_ready=0.
- Simultaneous events:
  - Out transfer and s1 advance in the same cycle: new result replaces old with no bubble.
  - In transfer and s1 advance in the same cycle: s1 reloads.
- Outputs change only on adv2. Inputs are ignored while in_ready=0.
- Reset mid-operation drops all in-flight data. No result is emitted after reset release until a new input transfer.
- Elaboration-time check: WIDTH % GROUPSIZE != 0 is a fatal error.

Test Plan:
- Add carry ripple across all groups: add, a=0x0000_0001, b=0xFFFF_FFFF, cin=0 -> 2 cycles later sum=0x0000_0000, cout=1, overflow=0, zero=1.
- Subtract with borrow: sub, a=5, b=7 -> sum=0xFFFF_FFFE, cout=0, overflow=0, zero=0. Then a=7, b=5 -> sum=2, cout=1.
- Signed overflow: add a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, overflow=1, cout=0. Sub a=0x8000_0000, b=1 -> sum=0x7FFF_FFFF, overflow=1.
- Back-to-back: 8 consecutive adds of i+i (i=0..7) with out_ready=1 and in_valid held high -> in_ready stays 1, sums 0,2,...,14 on 8 consecutive cycles starting 2 cycles after the first transfer.
- Backpressure: out_ready=0, offer 3 inputs -> only 2 accepted, in_ready=0 on the third, output stable. Raise out_ready -> results arrive in order with no loss or duplication.
- Reset mid-flight: 2 ops in flight, pulse rst_n low for half a cycle -> out_valid=0 immediately, sum=0, nothing emitted until the next input. Repeat with WIDTH=16, GROUPSIZE=8: 0xFFFF+1 -> sum=0, cout=1.
